irq_scanline_gen: RTL and testbench

IRQ_SCANLINE_GEN -- requirements
Module: irq_scanline_gen

---
 rtl/irq_scanline_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_irq_scanline_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_scanline_gen.sv
// Scanline IRQ generator: counts deglitched PPU A12 rises and raises a CPU IRQ
// when a reloadable down-counter reaches zero, with save-state readback/restore.
module irq_scanline_gen #(
    parameter int CTR_W       = 8,
    parameter int PRESCALE    = 1,
    parameter int FILT_LEN    = 2,
    parameter int LOW_MIN     = 0,
    parameter int OLD_MODE    = 0,
    parameter int IRQ_ON_FALL = 0,
    parameter int SST_BASE    = 16
) (
    input  logic       clk_i,
    input  logic       map_rst_i,
    input  logic       cpu_m3_i,
    input  logic       cpu_rw_i,
    input  logic [7:0] cpu_data_i,
    input  logic [3:0] reg_addr_i,
    input  logic       ppu_a12_i,
    output logic       irq_o,
    input  logic [7:0] sst_addr_i,
    input  logic [7:0] sst_dato_i,
    input  logic       sst_we_reg_i,
    input  logic       sst_act_mc_i,
    output logic [7:0] sst_di_o
);

    localparam int PH_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int LOW_W = $clog2(LOW_MIN + 2);

    localparam logic [15:0]      CTR_MASK = 16'((32'd1 << CTR_W) - 32'd1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PRESCALE - 1);
    localparam logic [LOW_W-1:0] LOW_MAX  = '1;

    localparam logic [3:0] REG_B = 4'hB;
    localparam logic [3:0] REG_C = 4'hC;
    localparam logic [3:0] REG_D = 4'hD;
    localparam logic [3:0] REG_E = 4'hE;
    localparam logic [3:0] REG_F = 4'hF;

    localparam logic [7:0] SST_I0 = 8'(SST_BASE + 0);
    localparam logic [7:0] SST_I1 = 8'(SST_BASE + 1);
    localparam logic [7:0] SST_I2 = 8'(SST_BASE + 2);
    localparam logic [7:0] SST_I3 = 8'(SST_BASE + 3);
    localparam logic [7:0] SST_I4 = 8'(SST_BASE + 4);
    localparam logic [7:0] SST_I5 = 8'(SST_BASE + 5);

    logic [FILT_LEN-1:0] filt_q, filt_d;
    logic                a12f_q, a12f_d;
    logic [LOW_W-1:0]    low_cnt_q, low_cnt_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [CTR_W-1:0]    ctr_q, ctr_d;
    logic [15:0]         reload_q, reload_d;
    logic                reload_req_q, reload_req_d;
    logic                irq_on_q, irq_on_d;
    logic                pend_q, pend_d;
    logic                irq_q, irq_d;
    logic [7:0]          sst_di_q, sst_di_d;

    logic                wr_s, rise_s, fall_s, accept_s, low_ok_s;
    logic                ctr_clk_s, trigger_s, pend_set_s;
    logic [CTR_W-1:0]    ctr_next_s;
    logic [15:0]         ctr16_s;

    // A rise only counts after A12 has been low long enough (rejects short re-rises)
    if (LOW_MIN == 0) begin : g_no_low_check
        assign low_ok_s = 1'b1;
    end else begin : g_low_check
        assign low_ok_s = (low_cnt_q >= LOW_W'(LOW_MIN));
    end

    // Next-state logic: filter, prescaler, counter, IRQ, register and save-state access
    always_comb begin
        filt_d       = FILT_LEN'({filt_q, ppu_a12_i});
        a12f_d       = a12f_q;
        low_cnt_d    = low_cnt_q;
        phase_d      = phase_q;
        ctr_d        = ctr_q;
        reload_d     = reload_q;
        reload_req_d = reload_req_q;
        irq_on_d     = irq_on_q;
        pend_d       = pend_q;
        irq_d        = irq_q;
        sst_di_d     = 8'hFF;
        pend_set_s   = 1'b0;
        trigger_s    = 1'b0;
        ctr16_s      = 16'(ctr_q);

        wr_s = cpu_m3_i & ~cpu_rw_i & ~sst_act_mc_i;

        if (&filt_q) begin
            a12f_d = 1'b1;
        end else if (~|filt_q) begin
            a12f_d = 1'b0;
        end else begin
            a12f_d = a12f_q;
        end
        rise_s = a12f_d & ~a12f_q;
        fall_s = ~a12f_d & a12f_q;

        if (a12f_q) begin
            low_cnt_d = '0;
        end else if (low_cnt_q != LOW_MAX) begin
            low_cnt_d = low_cnt_q + LOW_W'(1);
        end else begin
            low_cnt_d = low_cnt_q;
        end

        accept_s   = rise_s & low_ok_s & ~sst_act_mc_i;
        ctr_clk_s  = accept_s & (phase_q == '0);
        ctr_next_s = (ctr_q == '0) ? reload_q[CTR_W-1:0] : ctr_q - CTR_W'(1);

        if (OLD_MODE == 0) begin
            trigger_s = (ctr_next_s == '0);
        end else begin
            trigger_s = (ctr_next_s == '0) & ((ctr_q != '0) | reload_req_q);
        end

        if (sst_act_mc_i) begin
            if (cpu_m3_i && sst_we_reg_i) begin
                case (sst_addr_i)
                    SST_I0:  reload_d = {reload_q[15:8], sst_dato_i} & CTR_MASK;
                    SST_I1:  irq_on_d = sst_dato_i[0];
                    SST_I2:  ctr_d    = CTR_W'({ctr16_s[15:8], sst_dato_i} & CTR_MASK);
                    SST_I4:  reload_d = {sst_dato_i, reload_q[7:0]} & CTR_MASK;
                    SST_I5:  ctr_d    = CTR_W'({sst_dato_i, ctr16_s[7:0]} & CTR_MASK);
                    default: reload_d = reload_q;
                endcase
            end else begin
                reload_d = reload_q;
            end
            irq_d = pend_q;
        end else begin
            if (accept_s) begin
                phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
            end else begin
                phase_d = phase_q;
            end

            if (ctr_clk_s) begin
                ctr_d        = ctr_next_s;
                reload_req_d = 1'b0;
                pend_set_s   = trigger_s;
            end else begin
                pend_set_s   = 1'b0;
            end

            // A D write overrides a coincident counter clock and its trigger
            if (wr_s) begin
                case (reg_addr_i)
                    REG_B:   reload_d = {cpu_data_i, reload_q[7:0]} & CTR_MASK;
                    REG_C:   reload_d = {reload_q[15:8], cpu_data_i} & CTR_MASK;
                    REG_D: begin
                        reload_req_d = 1'b1;
                        ctr_d        = '0;
                        phase_d      = '0;
                        pend_set_s   = 1'b0;
                    end
                    REG_E:   irq_on_d = 1'b0;
                    REG_F:   irq_on_d = 1'b1;
                    default: irq_on_d = irq_on_q;
                endcase
            end else begin
                irq_on_d = irq_on_q;
            end

            if (!irq_on_d) begin
                pend_d = 1'b0;
                irq_d  = 1'b0;
            end else begin
                pend_d = pend_q | pend_set_s;
                if (IRQ_ON_FALL == 0) begin
                    irq_d = pend_q;
                end else if (fall_s) begin
                    irq_d = pend_q;
                end else begin
                    irq_d = irq_q;
                end
            end
        end

        case (sst_addr_i)
            SST_I0:  sst_di_d = reload_q[7:0];
            SST_I1:  sst_di_d = {7'b0, irq_on_q};
            SST_I2:  sst_di_d = ctr16_s[7:0];
            SST_I3:  sst_di_d = {6'b0, reload_req_q, pend_q};
            SST_I4:  sst_di_d = reload_q[15:8];
            SST_I5:  sst_di_d = ctr16_s[15:8];
            default: sst_di_d = 8'hFF;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (map_rst_i) begin
            filt_q       <= '0;
            a12f_q       <= 1'b0;
            low_cnt_q    <= '0;
            phase_q      <= '0;
            ctr_q        <= '0;
            reload_q     <= 16'h0000;
            reload_req_q <= 1'b0;
            irq_on_q     <= 1'b0;
            pend_q       <= 1'b0;
            irq_q        <= 1'b0;
            sst_di_q     <= 8'h00;
        end else begin
            filt_q       <= filt_d;
            a12f_q       <= a12f_d;
            low_cnt_q    <= low_cnt_d;
            phase_q      <= phase_d;
            ctr_q        <= ctr_d;
            reload_q     <= reload_d;
            reload_req_q <= reload_req_d;
            irq_on_q     <= irq_on_d;
            pend_q       <= pend_d;
            irq_q        <= irq_d;
            sst_di_q     <= sst_di_d;
        end
    end

    assign irq_o    = irq_q;
    assign sst_di_o = sst_di_q;

endmodule

// File: tb/tb_irq_scanline_gen.sv
// Directed bench for irq_scanline_gen: six parameterisations share one stimulus
// bus; each scenario checks only the instance it targets.
module tb_irq_scanline_gen;

    localparam int SST_BASE = 16;

    logic       clk = 1'b0;
    logic       map_rst = 1'b1;
    logic       cpu_m3 = 1'b0;
    logic       cpu_rw = 1'b1;
    logic [7:0] cpu_data = 8'h00;
    logic [3:0] reg_addr = 4'h0;
    logic       ppu_a12 = 1'b0;
    logic [7:0] sst_addr = 8'h00;
    logic [7:0] sst_dato = 8'h00;
    logic       sst_we_reg = 1'b0;
    logic       sst_act_mc = 1'b0;
    logic       irq_w [6];
    logic [7:0] di_w  [6];

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] saved   [7];
    logic [7:0] sst_exp [7] = '{8'h23, 8'h01, 8'hFE, 8'h00, 8'h01, 8'h00, 8'hFF};

    always #5 clk = ~clk;

    irq_scanline_gen u0 (
        .clk_i(clk), .map_rst_i(map_rst), .cpu_m3_i(cpu_m3), .cpu_rw_i(cpu_rw),
        .cpu_data_i(cpu_data), .reg_addr_i(reg_addr), .ppu_a12_i(ppu_a12), .irq_o(irq_w[0]),
        .sst_addr_i(sst_addr), .sst_dato_i(sst_dato), .sst_we_reg_i(sst_we_reg),
        .sst_act_mc_i(sst_act_mc), .sst_di_o(di_w[0]));

    irq_scanline_gen #(.PRESCALE(8)) u1 (
        .clk_i(clk), .map_rst_i(map_rst), .cpu_m3_i(cpu_m3), .cpu_rw_i(cpu_rw),
        .cpu_data_i(cpu_data), .reg_addr_i(reg_addr), .ppu_a12_i(ppu_a12), .irq_o(irq_w[1]),
        .sst_addr_i(sst_addr), .sst_dato_i(sst_dato), .sst_we_reg_i(sst_we_reg),
        .sst_act_mc_i(sst_act_mc), .sst_di_o(di_w[1]));

    irq_scanline_gen #(.FILT_LEN(2), .LOW_MIN(6)) u2 (
        .clk_i(clk), .map_rst_i(map_rst), .cpu_m3_i(cpu_m3), .cpu_rw_i(cpu_rw),
        .cpu_data_i(cpu_data), .reg_addr_i(reg_addr), .ppu_a12_i(ppu_a12), .irq_o(irq_w[2]),
        .sst_addr_i(sst_addr), .sst_dato_i(sst_dato), .sst_we_reg_i(sst_we_reg),
        .sst_act_mc_i(sst_act_mc), .sst_di_o(di_w[2]));

    irq_scanline_gen #(.OLD_MODE(1)) u3 (
        .clk_i(clk), .map_rst_i(map_rst), .cpu_m3_i(cpu_m3), .cpu_rw_i(cpu_rw),
        .cpu_data_i(cpu_data), .reg_addr_i(reg_addr), .ppu_a12_i(ppu_a12), .irq_o(irq_w[3]),
        .sst_addr_i(sst_addr), .sst_dato_i(sst_dato), .sst_we_reg_i(sst_we_reg),
        .sst_act_mc_i(sst_act_mc), .sst_di_o(di_w[3]));

    irq_scanline_gen #(.IRQ_ON_FALL(1)) u4 (
        .clk_i(clk), .map_rst_i(map_rst), .cpu_m3_i(cpu_m3), .cpu_rw_i(cpu_rw),
        .cpu_data_i(cpu_data), .reg_addr_i(reg_addr), .ppu_a12_i(ppu_a12), .irq_o(irq_w[4]),
        .sst_addr_i(sst_addr), .sst_dato_i(sst_dato), .sst_we_reg_i(sst_we_reg),
        .sst_act_mc_i(sst_act_mc), .sst_di_o(di_w[4]));

    irq_scanline_gen #(.CTR_W(12)) u5 (
        .clk_i(clk), .map_rst_i(map_rst), .cpu_m3_i(cpu_m3), .cpu_rw_i(cpu_rw),
        .cpu_data_i(cpu_data), .reg_addr_i(reg_addr), .ppu_a12_i(ppu_a12), .irq_o(irq_w[5]),
        .sst_addr_i(sst_addr), .sst_dato_i(sst_dato), .sst_we_reg_i(sst_we_reg),
        .sst_act_mc_i(sst_act_mc), .sst_di_o(di_w[5]));

    task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Advance n clocks, landing 1 time unit after the last rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        cpu_m3 = 1'b1; cpu_rw = 1'b0; reg_addr = a; cpu_data = d;
        tick(1);
        cpu_m3 = 1'b0; cpu_rw = 1'b1;
    endtask

    task automatic do_reset();
        map_rst = 1'b1;
        tick(1);
        map_rst = 1'b0;
        tick(1);
    endtask

    task automatic sel(input int idx);
        sst_addr = 8'(SST_BASE + idx);
        tick(2);
    endtask

    // Raise A12; the filtered rise lands on the third edge, where an optional write coincides
    task automatic up(input logic wr_en, input logic [3:0] a, input logic [7:0] d);
        ppu_a12 = 1'b1;
        tick(2);
        if (wr_en) begin
            cpu_m3 = 1'b1; cpu_rw = 1'b0; reg_addr = a; cpu_data = d;
        end
        tick(1);
        cpu_m3 = 1'b0; cpu_rw = 1'b1;
        tick(1);
    endtask

    task automatic down(input int n);
        ppu_a12 = 1'b0;
        tick(n);
    endtask

    task automatic rise();
        up(1'b0, 4'h0, 8'h00);
        down(6);
    endtask

    initial begin
        tick(1);
        do_reset();

        // Reset state
        sel(2); check_val("rst_ctr", di_w[0], 8'h00);
        check_val("rst_irq", 8'(irq_w[0]), 8'h00);
        sel(3); check_val("rst_flags", di_w[0], 8'h00);
        sel(1); check_val("rst_irq_on", di_w[0], 8'h00);
        sel(6); check_val("sst_bad_idx", di_w[0], 8'hFF);

        // Basic count-down with reload 3
        do_reset();
        wr(4'hC, 8'h03); wr(4'hD, 8'h00); wr(4'hF, 8'h00);
        sel(2);
        for (int r = 1; r <= 4; r++) begin
            up(1'b0, 4'h0, 8'h00);
            if (r == 3) check_val("basic_irq_early", 8'(irq_w[0]), 8'h00);
            if (r == 4) check_val("basic_irq", 8'(irq_w[0]), 8'h01);
            down(6);
            check_val("basic_ctr", di_w[0], 8'(4 - r));
        end
        sel(3); check_val("basic_pend", di_w[0], 8'h01);
        wr(4'hE, 8'h00);
        check_val("basic_irq_off", 8'(irq_w[0]), 8'h00);

        // F coinciding with a trigger, then D coinciding with a counter clock
        do_reset();
        wr(4'hC, 8'h01); wr(4'hD, 8'h00);
        sel(2);
        rise();
        check_val("coll_ctr1", di_w[0], 8'h01);
        up(1'b1, 4'hF, 8'h00);
        check_val("f_trig_irq", 8'(irq_w[0]), 8'h01);
        down(6);
        wr(4'hE, 8'h00); wr(4'hF, 8'h00); wr(4'hD, 8'h00);
        rise();
        check_val("coll_ctr2", di_w[0], 8'h01);
        up(1'b1, 4'hD, 8'h00);
        check_val("d_coll_irq", 8'(irq_w[0]), 8'h00);
        down(6);
        check_val("d_coll_ctr", di_w[0], 8'h00);
        sel(3); check_val("d_coll_flags", di_w[0], 8'h02);

        // Prescale by 8
        do_reset();
        wr(4'hC, 8'h01); wr(4'hD, 8'h00); wr(4'hF, 8'h00);
        sel(2);
        for (int r = 1; r <= 16; r++) begin
            up(1'b0, 4'h0, 8'h00);
            if (r == 9) check_val("ps_irq9", 8'(irq_w[1]), 8'h01);
            down(6);
            if (r == 1) check_val("ps_ctr1", di_w[1], 8'h01);
            if (r == 8) begin
                check_val("ps_ctr8", di_w[1], 8'h01);
                check_val("ps_irq8", 8'(irq_w[1]), 8'h00);
            end
            if (r == 16) check_val("ps_ctr16", di_w[1], 8'h00);
        end

        // Deglitch and minimum low time
        do_reset();
        wr(4'hC, 8'h05); wr(4'hD, 8'h00); wr(4'hF, 8'h00);
        tick(8);
        sel(2);
        up(1'b0, 4'h0, 8'h00);
        check_val("low_first", di_w[2], 8'h05);
        ppu_a12 = 1'b0; tick(3);
        ppu_a12 = 1'b1; tick(4);
        check_val("low_rerise", di_w[2], 8'h05);
        ppu_a12 = 1'b0; tick(1);
        ppu_a12 = 1'b1; tick(4);
        check_val("low_glitch", di_w[2], 8'h05);
        down(8);
        up(1'b0, 4'h0, 8'h00);
        check_val("low_long", di_w[2], 8'h04);

        // Reload zero, old vs new mode
        do_reset();
        wr(4'hF, 8'h00);
        up(1'b0, 4'h0, 8'h00);
        check_val("old0_fire", 8'(irq_w[0]), 8'h01);
        check_val("old1_nofire", 8'(irq_w[3]), 8'h00);
        down(6);
        wr(4'hD, 8'h00);
        up(1'b0, 4'h0, 8'h00);
        check_val("old1_after_d", 8'(irq_w[3]), 8'h01);
        down(6);
        wr(4'hE, 8'h00); wr(4'hF, 8'h00);
        up(1'b0, 4'h0, 8'h00);
        check_val("old0_again", 8'(irq_w[0]), 8'h01);
        check_val("old1_once", 8'(irq_w[3]), 8'h00);
        down(6);

        // IRQ on A12 fall, then reset mid-count with a write in the reset cycle
        do_reset();
        wr(4'hC, 8'h01); wr(4'hD, 8'h00); wr(4'hF, 8'h00);
        sel(2);
        rise();
        up(1'b0, 4'h0, 8'h00);
        check_val("fall_wait", 8'(irq_w[4]), 8'h00);
        sel(3); check_val("fall_pend", di_w[4], 8'h01);
        down(6);
        check_val("fall_irq", 8'(irq_w[4]), 8'h01);
        sel(2);
        rise();
        check_val("mid_ctr", di_w[4], 8'h01);
        map_rst = 1'b1; cpu_m3 = 1'b1; cpu_rw = 1'b0; reg_addr = 4'hF;
        tick(1);
        map_rst = 1'b0; cpu_m3 = 1'b0; cpu_rw = 1'b1;
        tick(1);
        check_val("mrst_irq", 8'(irq_w[4]), 8'h00);
        sel(2); check_val("mrst_ctr", di_w[4], 8'h00);
        sel(3); check_val("mrst_flags", di_w[4], 8'h00);
        sel(1); check_val("mrst_irq_on", di_w[4], 8'h00);

        // 12-bit counter save/restore
        do_reset();
        wr(4'hB, 8'h01); wr(4'hC, 8'h23); wr(4'hD, 8'h00); wr(4'hF, 8'h00);
        sel(2);
        repeat (38) rise();
        check_val("w12_ctr", di_w[5], 8'hFE);
        sst_act_mc = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sel(i);
            saved[i] = di_w[5];
            check_val("sst_save", di_w[5], sst_exp[i]);
        end
        sst_act_mc = 1'b0;
        sel(2);
        repeat (5) rise();
        check_val("w12_run", di_w[5], 8'hF9);
        sst_act_mc = 1'b1; cpu_m3 = 1'b1; sst_we_reg = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i != 3) begin
                sst_addr = 8'(SST_BASE + i);
                sst_dato = saved[i];
                tick(1);
            end
        end
        cpu_m3 = 1'b0; sst_we_reg = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sel(i);
            check_val("sst_restore", di_w[5], sst_exp[i]);
        end
        sst_act_mc = 1'b0;
        sel(2);
        rise();
        check_val("w12_resume", di_w[5], 8'hFD);
        sel(5); check_val("w12_resume_hi", di_w[5], 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
